// File: rtl/mem_line_arbiter.sv
// Arbitrates NUM_REQ L1 controllers onto one line-wide memory port.
// Round-robin with optional writeback priority; one transaction in flight.
module mem_line_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LINE_BITS   = 512,
    parameter int unsigned WB_PRIORITY = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LINE_BITS-1:0]    req_wline,
    output logic [NUM_REQ-1:0]              req_ack,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [LINE_BITS-1:0]            resp_rline,
    output logic                            mem_req,
    output logic                            mem_wr,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [LINE_BITS-1:0]            mem_wline,
    input  logic                            mem_ready,
    input  logic [LINE_BITS-1:0]            mem_rline,
    output logic                            busy,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0]    mem_wline_q, mem_wline_d;
    logic [NUM_REQ-1:0]      req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]      resp_valid_q, resp_valid_d;
    logic [LINE_BITS-1:0]    resp_rline_q, resp_rline_d;
    logic                    busy_q, busy_d;

    logic [NUM_REQ-1:0]      wr_pend;
    logic [NUM_REQ-1:0]      cand;
    logic [GW-1:0]           win;

    // First set bit of mask strictly after ptr, wrapping; the pointer itself is checked last.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                              input logic [GW-1:0]      ptr);
        logic [GW-1:0] pick;
        logic          hit;
        int unsigned   idx;
        pick = ptr;
        hit  = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!hit && mask[idx[GW-1:0]]) begin
                pick = idx[GW-1:0];
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign wr_pend = req_valid & req_wr;
    assign cand    = (WB_PRIORITY != 0 && |wr_pend) ? wr_pend : req_valid;
    assign win     = rr_pick(cand, ptr_q);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        mem_req_d    = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wline_d  = mem_wline_q;
        req_ack_d    = '0;
        resp_valid_d = '0;
        resp_rline_d = resp_rline_q;
        busy_d       = busy_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ptr_d            = win;
                    grant_id_d       = win;
                    mem_req_d        = 1'b1;
                    mem_wr_d         = req_wr[win];
                    mem_addr_d       = req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wline_d      = req_wline[32'(win)*LINE_BITS +: LINE_BITS];
                    req_ack_d[win]   = 1'b1;
                    busy_d           = 1'b1;
                    state_d          = WAIT;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    resp_valid_d[grant_id_q] = 1'b1;
                    // mem_wr_q still describes the in-flight transaction here
                    if (!mem_wr_q) resp_rline_d = mem_rline;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= GW'(NUM_REQ - 1);
            grant_id_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wline_q  <= '0;
            req_ack_q    <= '0;
            resp_valid_q <= '0;
            resp_rline_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_id_q   <= grant_id_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wline_q  <= mem_wline_d;
            req_ack_q    <= req_ack_d;
            resp_valid_q <= resp_valid_d;
            resp_rline_q <= resp_rline_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ack    = req_ack_q;
    assign resp_valid = resp_valid_q;
    assign resp_rline = resp_rline_q;
    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wline  = mem_wline_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter: arbitration table plus handshake/reset sequences.
// A second instance with pure round-robin shares the stimulus for the priority comparison.
module tb_mem_line_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LB  = 512;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*LB-1:0] req_wline;
    logic [N-1:0]    req_ack, resp_valid;
    logic [LB-1:0]   resp_rline;
    logic            mem_req, mem_wr, mem_ready, model_ready, force_rdy, busy;
    logic [AW-1:0]   mem_addr;
    logic [LB-1:0]   mem_wline, mem_rline;
    logic [1:0]      grant_id;

    logic [N-1:0]    rr_req_ack, rr_resp_valid;
    logic [LB-1:0]   rr_resp_rline, rr_mem_wline;
    logic [LB-1:0]   rr_mem_rline = '0;
    logic            rr_mem_req, rr_mem_wr, rr_mem_ready, rr_busy;
    logic [AW-1:0]   rr_mem_addr;
    logic [1:0]      rr_grant_id;
    logic [2:0]      rr_sh;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_line_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .WB_PRIORITY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wline(req_wline), .req_ack(req_ack), .resp_valid(resp_valid), .resp_rline(resp_rline),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wline(mem_wline),
        .mem_ready(mem_ready), .mem_rline(mem_rline), .busy(busy), .grant_id(grant_id));

    mem_line_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LINE_BITS(LB), .WB_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wline(req_wline), .req_ack(rr_req_ack), .resp_valid(rr_resp_valid),
        .resp_rline(rr_resp_rline), .mem_req(rr_mem_req), .mem_wr(rr_mem_wr),
        .mem_addr(rr_mem_addr), .mem_wline(rr_mem_wline), .mem_ready(rr_mem_ready),
        .mem_rline(rr_mem_rline), .busy(rr_busy), .grant_id(rr_grant_id));

    // Line memory with fixed latency LAT, indexed by address bits [9:6].
    logic [LB-1:0] mem_arr [16];
    logic [3:0]    cnt, line_idx;
    logic          pend_wr;
    logic [LB-1:0] pend_line;

    initial foreach (mem_arr[i]) mem_arr[i] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            model_ready <= 1'b0;
            mem_rline   <= '0;
        end else begin
            model_ready <= 1'b0;
            if (mem_req) begin
                cnt       <= 4'(LAT);
                line_idx  <= mem_addr[9:6];
                pend_wr   <= mem_wr;
                pend_line <= mem_wline;
            end else if (cnt != 0) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    model_ready <= 1'b1;
                    if (pend_wr) mem_arr[line_idx] <= pend_line;
                    else         mem_rline <= mem_arr[line_idx];
                end
            end
        end
    end
    assign mem_ready = model_ready | force_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) rr_sh <= '0;
        else     rr_sh <= {rr_sh[1:0], rr_mem_req};
    end
    assign rr_mem_ready = rr_sh[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Protocol invariants sampled on every falling edge.
    logic in_flight, rdy_prev;
    always @(negedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
            rdy_prev  <= 1'b0;
        end else begin
            if (mem_req) begin
                check("no_overlap", 64'(in_flight), 64'd0);
                check("ack_with_req", 64'(req_ack), 64'(4'b0001 << grant_id));
                check("busy_at_grant", 64'(busy), 64'd1);
            end
            if (resp_valid != 0) begin
                check("resp_1cyc_after_ready", 64'(rdy_prev), 64'd1);
                check("resp_onehot", 64'($onehot(resp_valid)), 64'd1);
            end
            if (mem_req)        in_flight <= 1'b1;
            else if (mem_ready) in_flight <= 1'b0;
            rdy_prev <= mem_ready;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_wr = '0; force_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [LB-1:0] l);
        req_addr[i*AW +: AW]  = a;
        req_wline[i*LB +: LB] = l;
    endtask

    task automatic wait_grant(output int gid);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = mem_req;
        end
        if (got) gid = int'(grant_id);
        else begin
            gid = -1;
            check("grant_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic wait_resp(input int idx);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            got = (resp_valid != 0);
            if (!got) check("busy_in_flight", 64'(busy), 64'd1);
        end
        if (got) begin
            check("resp_id", 64'(resp_valid), 64'(4'b0001 << idx));
            check("busy_after_resp", 64'(busy), 64'd0);
        end else check("resp_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] wr;
        int           g_wb;
        int           g_rr;
    } vec_t;

    initial begin
        vec_t vecs[8];
        int   g;
        int   order[5];
        bit   seen;
        logic [AW-1:0] a;
        logic [LB-1:0] a5_line;

        vecs[0] = '{4'b0001, 4'b0000, 0, 0};
        vecs[1] = '{4'b1001, 4'b1000, 3, 0};
        vecs[2] = '{4'b0110, 4'b0000, 1, 1};
        vecs[3] = '{4'b1100, 4'b0100, 2, 2};
        vecs[4] = '{4'b1010, 4'b1000, 3, 1};
        vecs[5] = '{4'b1111, 4'b0110, 1, 0};
        vecs[6] = '{4'b1000, 4'b0000, 3, 3};
        vecs[7] = '{4'b0101, 4'b0100, 2, 0};
        order   = '{0, 1, 2, 3, 0};
        a5_line = {64{8'hA5}};

        rst = 1'b1; req_valid = '0; req_wr = '0; force_rdy = 1'b0;
        req_addr = '0; req_wline = '0;
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_req_ack", 64'(req_ack), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Arbitration table: each vector starts from reset (pointer at N-1).
        for (int k = 0; k < 8; k++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                set_slot(i, 32'h1000_0000 | 32'(k << 8) | 32'(i << 6), {16{32'(k * 16 + i)}});
            req_wr    = vecs[k].wr;
            req_valid = vecs[k].v;
            wait_grant(g);
            check("v_grant_wb", 64'(g), 64'(vecs[k].g_wb));
            check("v_grant_rr", 64'(rr_grant_id), 64'(vecs[k].g_rr));
            check("v_rr_mem_req", 64'(rr_mem_req), 64'd1);
            check("v_mem_wr", 64'(mem_wr), 64'(vecs[k].wr[vecs[k].g_wb]));
            a = 32'h1000_0000 | 32'(k << 8) | 32'(vecs[k].g_wb << 6);
            check("v_mem_addr", 64'(mem_addr), 64'(a));
            check("v_mem_wline", 64'(mem_wline[31:0]), 64'(k * 16 + vecs[k].g_wb));
            req_valid = '0;
            wait_resp(vecs[k].g_wb);
        end

        // Write then read of the same line by requester 2.
        do_reset();
        set_slot(2, 32'h0000_1040, a5_line);
        req_wr = 4'b0100; req_valid = 4'b0100;
        wait_grant(g);
        check("t1_wr_grant", 64'(g), 64'd2);
        check("t1_wr_ack", 64'(req_ack), 64'h4);
        check("t1_wr_mem_wr", 64'(mem_wr), 64'd1);
        check("t1_wr_addr", 64'(mem_addr), 64'h1040);
        req_valid = '0;
        @(negedge clk);
        check("t1_req_pulse", 64'(mem_req), 64'd0);
        check("t1_ack_pulse", 64'(req_ack), 64'd0);
        check("t1_addr_hold", 64'(mem_addr), 64'h1040);
        wait_resp(2);
        set_slot(2, 32'h0000_1044, '0);
        req_wr = 4'b0000; req_valid = 4'b0100;
        wait_grant(g);
        check("t1_rd_grant", 64'(g), 64'd2);
        check("t1_rd_mem_wr", 64'(mem_wr), 64'd0);
        check("t1_rd_addr", 64'(mem_addr), 64'h1044);
        req_valid = '0;
        wait_resp(2);
        check("t1_rline_lo", 64'(resp_rline[63:0]), 64'(a5_line[63:0]));
        check("t1_rline_full", 64'(resp_rline == a5_line), 64'd1);

        // All four read continuously: strict rotation.
        do_reset();
        req_wr = '0; req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            check("t2_order", 64'(g), 64'(order[i]));
            if (i == 4) req_valid = '0;
            wait_resp(order[i]);
        end

        // req2 slips in ahead of req1's second grant.
        do_reset();
        req_valid = 4'b0010;
        wait_grant(g);
        check("t4_first", 64'(g), 64'd1);
        req_valid = 4'b0110;
        wait_resp(1);
        wait_grant(g);
        check("t4_second", 64'(g), 64'd2);
        req_valid = 4'b0010;
        wait_resp(2);
        wait_grant(g);
        check("t4_third", 64'(g), 64'd1);
        req_valid = '0;
        wait_resp(1);

        // Asynchronous reset with req1 in flight.
        do_reset();
        set_slot(1, 32'h0000_2080, '0);
        req_valid = 4'b0010;
        wait_grant(g);
        check("t5_grant", 64'(g), 64'd1);
        req_valid = '0;
        @(negedge clk);
        check("t5_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_grant_id", 64'(grant_id), 64'd0);
        check("t5_async_mem_addr", 64'(mem_addr), 64'd0);
        check("t5_async_mem_req", 64'(mem_req), 64'd0);
        check("t5_async_ack", 64'(req_ack), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid != 0) seen = 1'b1;
        end
        check("t5_no_resp", 64'(seen), 64'd0);
        req_valid = 4'b1010;
        wait_grant(g);
        check("t5_ptr_reset", 64'(g), 64'd1);
        req_valid = 4'b1000;
        wait_resp(1);
        wait_grant(g);
        check("t5_next", 64'(g), 64'd3);
        req_valid = '0;
        wait_resp(3);

        // Stray mem_ready while idle.
        do_reset();
        @(negedge clk);
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid != 0) seen = 1'b1;
        end
        check("t6_no_resp", 64'(seen), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        req_valid = 4'b0001;
        wait_grant(g);
        check("t6_grant_after", 64'(g), 64'd0);
        req_valid = '0;
        wait_resp(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
